// File: rtl/net_argmax_out.sv
// Classifier output stage: 1-based argmax over CLASS_NUM signed scores per frame,
// with frame-length checking. Define NET_OUT_MARGIN_EN to add top1-top2 margin tracking.
module net_argmax_out #(
    parameter int CLASS_NUM  = 10,
    parameter int DATA_W     = 8,
    parameter int IDX_W      = 8,
    parameter int MARGIN_MIN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              conv_start,
    input  logic              score_valid,
    input  logic [DATA_W-1:0] score_in,
    input  logic              frame_done,
    output logic              busy,
    output logic [IDX_W-1:0]  class_id,
    output logic [DATA_W-1:0] max_score,
    output logic              result_valid,
    output logic              len_err,
    output logic [DATA_W:0]   margin,
    output logic              low_conf
);

    localparam int CNT_W = $clog2(CLASS_NUM + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLASS_NUM);
    localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    if (CLASS_NUM < 2 || CLASS_NUM > 255 || (2 ** IDX_W) <= CLASS_NUM || MARGIN_MIN < 0) begin : g_param_chk
        $error("net_argmax_out: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [CNT_W-1:0]         idx_q, idx_d;
    logic signed [DATA_W-1:0] max_q, max_d;
    logic                     len_err_q, len_err_d;
    logic [IDX_W-1:0]         class_id_q, class_id_d;
    logic signed [DATA_W-1:0] max_score_q, max_score_d;
    logic                     result_valid_q, result_valid_d;

    logic signed [DATA_W-1:0] score_s;
    logic                     clear_acc;
    logic                     take_score;
    logic                     new_max;

    assign score_s = $signed(score_in);
    assign new_max = score_s > max_q;

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        idx_d          = idx_q;
        max_d          = max_q;
        len_err_d      = len_err_q;
        class_id_d     = class_id_q;
        max_score_d    = max_score_q;
        result_valid_d = 1'b0;
        clear_acc      = 1'b0;
        take_score     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (conv_start) begin
                    state_d   = S_ACCUM;
                    clear_acc = 1'b1;
                end
            end
            S_ACCUM: begin
                if (conv_start) begin
                    clear_acc = 1'b1;
                end else begin
                    if (score_valid) begin
                        if (count_q < CNT_FULL) begin
                            take_score = 1'b1;
                            count_d    = count_q + 1'b1;
                            if (new_max) begin
                                max_d = score_s;
                                idx_d = count_q;
                            end
                        end else begin
                            len_err_d = 1'b1;
                        end
                    end
                    // Length check sees the count including a score arriving this same cycle.
                    if (frame_done) begin
                        state_d = S_DONE;
                        if (count_d != CNT_FULL) len_err_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                class_id_d     = (count_q == '0) ? '0 : IDX_W'(idx_q) + IDX_W'(1);
                max_score_d    = max_q;
                result_valid_d = 1'b1;
                if (conv_start) begin
                    state_d   = S_ACCUM;
                    clear_acc = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (clear_acc) begin
            count_d   = '0;
            idx_d     = '0;
            max_d     = MOST_NEG;
            len_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            count_q        <= '0;
            idx_q          <= '0;
            max_q          <= MOST_NEG;
            len_err_q      <= 1'b0;
            class_id_q     <= '0;
            max_score_q    <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            idx_q          <= idx_d;
            max_q          <= max_d;
            len_err_q      <= len_err_d;
            class_id_q     <= class_id_d;
            max_score_q    <= max_score_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign busy         = (state_q == S_ACCUM);
    assign class_id     = class_id_q;
    assign max_score    = max_score_q;
    assign result_valid = result_valid_q;
    assign len_err      = len_err_q;

`ifdef NET_OUT_MARGIN_EN
    logic signed [DATA_W-1:0] second_q, second_d;
    logic [DATA_W:0]          margin_q;
    logic                     low_conf_q;

    // second never exceeds max, so the widened difference is always non-negative.
    function automatic logic [DATA_W:0] margin_calc(input logic signed [DATA_W-1:0] top1,
                                                    input logic signed [DATA_W-1:0] top2);
        logic signed [DATA_W:0] diff;
        diff = {top1[DATA_W-1], top1} - {top2[DATA_W-1], top2};
        return diff;
    endfunction

    always_comb begin
        second_d = second_q;
        if (clear_acc) begin
            second_d = MOST_NEG;
        end else if (take_score) begin
            if (new_max) second_d = max_q;
            else if (score_s > second_q) second_d = score_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            second_q   <= MOST_NEG;
            margin_q   <= '0;
            low_conf_q <= 1'b0;
        end else begin
            second_q <= second_d;
            if (state_q == S_DONE) begin
                margin_q   <= margin_calc(max_q, second_q);
                low_conf_q <= margin_calc(max_q, second_q) < (DATA_W+1)'(MARGIN_MIN);
            end
        end
    end

    assign margin   = margin_q;
    assign low_conf = low_conf_q;
`else
    assign margin   = '0;
    assign low_conf = 1'b0;
`endif

endmodule

// File: tb/tb_net_argmax_out.sv
// Directed testbench for net_argmax_out: per-scenario tasks with hand-computed expectations.
module tb_net_argmax_out;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       conv_start = 1'b0;
    logic       score_valid = 1'b0;
    logic [7:0] score_in = '0;
    logic       frame_done = 1'b0;
    logic       busy;
    logic [7:0] class_id;
    logic [7:0] max_score;
    logic       result_valid;
    logic       len_err;
    logic [8:0] margin;
    logic       low_conf;

    int pass_cnt = 0;
    int total_cnt = 0;
    int rv_seen = 0;
    int vec[$];

    net_argmax_out #(.CLASS_NUM(10), .DATA_W(8), .IDX_W(8), .MARGIN_MIN(4)) dut (
        .clk(clk), .rst(rst_n), .conv_start(conv_start), .score_valid(score_valid),
        .score_in(score_in), .frame_done(frame_done), .busy(busy), .class_id(class_id),
        .max_score(max_score), .result_valid(result_valid), .len_err(len_err),
        .margin(margin), .low_conf(low_conf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
        if (result_valid === 1'b1) rv_seen++;
    endtask

    task automatic start_frame;
        conv_start = 1'b1;
        tick();
        conv_start = 1'b0;
    endtask

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            score_valid = 1'b1;
            score_in = 8'(vec[i]);
            tick();
        end
        score_valid = 1'b0;
    endtask

    task automatic end_frame;
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        tick();
    endtask

    task automatic run_frame(input int n);
        start_frame();
        push(n);
        end_frame();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %0d want 0", busy); else pass_cnt++;
        total_cnt++; if (class_id !== 8'd0) $display("FAIL reset_class_id got %0d want 0", class_id); else pass_cnt++;
        total_cnt++; if (max_score !== 8'd0) $display("FAIL reset_max_score got %0d want 0", max_score); else pass_cnt++;
        total_cnt++; if (result_valid !== 1'b0) $display("FAIL reset_result_valid got %0d want 0", result_valid); else pass_cnt++;
        total_cnt++; if (len_err !== 1'b0) $display("FAIL reset_len_err got %0d want 0", len_err); else pass_cnt++;
        total_cnt++; if (margin !== 9'd0 || low_conf !== 1'b0)
            $display("FAIL reset_margin got %0d/%0d want 0/0", margin, low_conf); else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        vec = {3, 9, -2, 40, 7, 40, 0, 1, -5, 12};
        start_frame();
        total_cnt++; if (busy !== 1'b1) $display("FAIL basic_busy got %0d want 1", busy); else pass_cnt++;
        push(10);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        total_cnt++; if (result_valid !== 1'b0) $display("FAIL basic_rv_early got %0d want 0", result_valid); else pass_cnt++;
        tick();
        total_cnt++; if (result_valid !== 1'b1) $display("FAIL basic_rv got %0d want 1", result_valid); else pass_cnt++;
        total_cnt++; if (class_id !== 8'd4) $display("FAIL basic_class_id got %0d want 4", class_id); else pass_cnt++;
        total_cnt++; if (max_score !== 8'd40) $display("FAIL basic_max_score got %0d want 40", max_score); else pass_cnt++;
        total_cnt++; if (len_err !== 1'b0) $display("FAIL basic_len_err got %0d want 0", len_err); else pass_cnt++;
`ifdef NET_OUT_MARGIN_EN
        total_cnt++; if (margin !== 9'd0 || low_conf !== 1'b1)
            $display("FAIL basic_margin got %0d/%0d want 0/1", margin, low_conf); else pass_cnt++;
`else
        total_cnt++; if (margin !== 9'd0 || low_conf !== 1'b0)
            $display("FAIL basic_margin got %0d/%0d want 0/0", margin, low_conf); else pass_cnt++;
`endif
        tick();
        total_cnt++; if (result_valid !== 1'b0) $display("FAIL basic_rv_pulse got %0d want 0", result_valid); else pass_cnt++;
        total_cnt++; if (class_id !== 8'd4) $display("FAIL basic_hold got %0d want 4", class_id); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL basic_idle_busy got %0d want 0", busy); else pass_cnt++;
    endtask

    task automatic test_all_negative;
        vec = {-9, -3, -7, -4, -6, -5, -10, -20, -128, -8};
        run_frame(10);
        total_cnt++; if (class_id !== 8'd2) $display("FAIL neg_class_id got %0d want 2", class_id); else pass_cnt++;
        total_cnt++; if (max_score !== 8'hFD) $display("FAIL neg_max_score got %0h want fd", max_score); else pass_cnt++;
        total_cnt++; if (len_err !== 1'b0) $display("FAIL neg_len_err got %0d want 0", len_err); else pass_cnt++;
`ifdef NET_OUT_MARGIN_EN
        total_cnt++; if (margin !== 9'd1 || low_conf !== 1'b1)
            $display("FAIL neg_margin got %0d/%0d want 1/1", margin, low_conf); else pass_cnt++;
`endif
    endtask

    task automatic test_tie;
        vec = {7, 7, 7, 7, 7, 7, 7, 7, 7, 7};
        run_frame(10);
        total_cnt++; if (class_id !== 8'd1) $display("FAIL tie_class_id got %0d want 1", class_id); else pass_cnt++;
        total_cnt++; if (max_score !== 8'd7) $display("FAIL tie_max_score got %0d want 7", max_score); else pass_cnt++;
    endtask

    task automatic test_short_frame;
        vec = {1, 2, 3, 9, 4, 5, 6};
        run_frame(7);
        total_cnt++; if (class_id !== 8'd4) $display("FAIL short_class_id got %0d want 4", class_id); else pass_cnt++;
        total_cnt++; if (max_score !== 8'd9) $display("FAIL short_max_score got %0d want 9", max_score); else pass_cnt++;
        total_cnt++; if (len_err !== 1'b1) $display("FAIL short_len_err got %0d want 1", len_err); else pass_cnt++;
        tick();
        total_cnt++; if (len_err !== 1'b1) $display("FAIL short_len_err_sticky got %0d want 1", len_err); else pass_cnt++;
        start_frame();
        total_cnt++; if (len_err !== 1'b0) $display("FAIL short_len_err_clear got %0d want 0", len_err); else pass_cnt++;
    endtask

    task automatic test_long_frame;
        vec = {5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 100, 100};
        run_frame(12);
        total_cnt++; if (class_id !== 8'd10) $display("FAIL long_class_id got %0d want 10", class_id); else pass_cnt++;
        total_cnt++; if (max_score !== 8'd14) $display("FAIL long_max_score got %0d want 14", max_score); else pass_cnt++;
        total_cnt++; if (len_err !== 1'b1) $display("FAIL long_len_err got %0d want 1", len_err); else pass_cnt++;
    endtask

    task automatic test_valid_with_done;
        vec = {1, 1, 1, 1, 1, 1, 1, 1, 1, 2};
        start_frame();
        push(9);
        score_valid = 1'b1;
        score_in = 8'd2;
        frame_done = 1'b1;
        tick();
        score_valid = 1'b0;
        frame_done = 1'b0;
        tick();
        total_cnt++; if (result_valid !== 1'b1) $display("FAIL vwd_rv got %0d want 1", result_valid); else pass_cnt++;
        total_cnt++; if (class_id !== 8'd10) $display("FAIL vwd_class_id got %0d want 10", class_id); else pass_cnt++;
        total_cnt++; if (max_score !== 8'd2) $display("FAIL vwd_max_score got %0d want 2", max_score); else pass_cnt++;
        total_cnt++; if (len_err !== 1'b0) $display("FAIL vwd_len_err got %0d want 0", len_err); else pass_cnt++;
    endtask

    task automatic test_restart;
        tick();
        rv_seen = 0;
        vec = {100, 100, 100, 100, 100};
        start_frame();
        push(5);
        vec = {1, 2, 3, 4, 5, 6, 7, 8, 20, 9};
        run_frame(10);
        tick();
        tick();
        total_cnt++; if (class_id !== 8'd9) $display("FAIL restart_class_id got %0d want 9", class_id); else pass_cnt++;
        total_cnt++; if (max_score !== 8'd20) $display("FAIL restart_max_score got %0d want 20", max_score); else pass_cnt++;
        total_cnt++; if (rv_seen !== 1) $display("FAIL restart_rv_count got %0d want 1", rv_seen); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        vec = {3, 9, -2, 40, 7, 40, 0, 1, -5, 12};
        start_frame();
        push(10);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        conv_start = 1'b1;
        tick();
        conv_start = 1'b0;
        total_cnt++; if (result_valid !== 1'b1) $display("FAIL b2b_rv got %0d want 1", result_valid); else pass_cnt++;
        total_cnt++; if (class_id !== 8'd4) $display("FAIL b2b_class_id1 got %0d want 4", class_id); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_busy got %0d want 1", busy); else pass_cnt++;
        vec = {-50, -40, -30, -20, -10, -60, -70, -80, -90, -100};
        push(10);
        end_frame();
        total_cnt++; if (class_id !== 8'd5) $display("FAIL b2b_class_id2 got %0d want 5", class_id); else pass_cnt++;
        total_cnt++; if (max_score !== 8'hF6) $display("FAIL b2b_max_score got %0h want f6", max_score); else pass_cnt++;
        total_cnt++; if (len_err !== 1'b0) $display("FAIL b2b_len_err got %0d want 0", len_err); else pass_cnt++;
    endtask

    task automatic test_async_reset;
        vec = {10, 20, 30, 40};
        start_frame();
        push(4);
        total_cnt++; if (busy !== 1'b1) $display("FAIL arst_pre_busy got %0d want 1", busy); else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL arst_busy got %0d want 0", busy); else pass_cnt++;
        total_cnt++; if (class_id !== 8'd0) $display("FAIL arst_class_id got %0d want 0", class_id); else pass_cnt++;
        total_cnt++; if (max_score !== 8'd0) $display("FAIL arst_max_score got %0d want 0", max_score); else pass_cnt++;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        vec = {3, 9, -2, 40, 7, 40, 0, 1, -5, 12};
        run_frame(10);
        total_cnt++; if (class_id !== 8'd4) $display("FAIL arst_after_class_id got %0d want 4", class_id); else pass_cnt++;
        total_cnt++; if (max_score !== 8'd40) $display("FAIL arst_after_max_score got %0d want 40", max_score); else pass_cnt++;
        total_cnt++; if (len_err !== 1'b0) $display("FAIL arst_after_len_err got %0d want 0", len_err); else pass_cnt++;
    endtask

`ifdef NET_OUT_MARGIN_EN
    task automatic test_margin;
        vec = {10, 8, 1, 2, 3, 4, 5, 6, 7, 0};
        run_frame(10);
        total_cnt++; if (margin !== 9'd2 || low_conf !== 1'b1)
            $display("FAIL margin_low got %0d/%0d want 2/1", margin, low_conf); else pass_cnt++;
        vec = {50, 20, 1, 2, 3, 4, 5, 6, 7, 0};
        run_frame(10);
        total_cnt++; if (margin !== 9'd30 || low_conf !== 1'b0)
            $display("FAIL margin_high got %0d/%0d want 30/0", margin, low_conf); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_all_negative();
        test_tie();
        test_short_frame();
        test_long_frame();
        test_valid_with_done();
        test_restart();
        test_back_to_back();
        test_async_reset();
`ifdef NET_OUT_MARGIN_EN
        test_margin();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
